// File: rtl/drum_pkg.sv
// Shared definitions for the drum voice: default geometry, voice-select and state encodings,
// and the stand-in sample tables used by the voice ROM.
package drum_pkg;

  localparam int SAMPLE_LEN = 4096;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;

  typedef enum logic [1:0] {
    VOICE_KICK  = 2'b00,
    VOICE_SNARE = 2'b01,
    VOICE_HAT   = 2'b10,
    VOICE_CLAP  = 2'b11
  } voice_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  // Each voice is a 0..127 ramp.
  // The ramp starts at a per-voice offset, so that every voice can be told apart by its first sample.
  // The snare ramp starts at 0.
  function automatic logic [7:0] sample_word(input logic [1:0] voice, input logic [6:0] idx);
    logic [6:0] s;
    s = idx + {voice ^ VOICE_SNARE, 5'b0_0000};
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/voice_rom.sv
// Four-voice sample ROM with one registered synchronous read port.
// The address is {voice, sample index}.
module voice_rom #(
  parameter int ADDR_W = drum_pkg::ADDR_W,
  parameter int DATA_W = drum_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W+1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (en) begin
      data <= DATA_W'(drum_pkg::sample_word(addr[ADDR_W+1:ADDR_W], 7'(addr[ADDR_W-1:0])));
    end
  end

endmodule

// File: rtl/drum_voice.sv
// One drum voice.
// A step trigger starts sample playback, and each 48 kHz strobe fetches the next sample into out with a two-clock latency.
module drum_voice #(
  parameter int SAMPLE_LEN = drum_pkg::SAMPLE_LEN,
  parameter int ADDR_W     = drum_pkg::ADDR_W,
  parameter int DATA_W     = drum_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_clk,
  input  logic                     slow_clk,
  input  logic                     play,
  input  logic                     ins_signal,
  input  logic [1:0]               sel,
  output logic signed [DATA_W-1:0] out,
  output logic                     busy
);

  import drum_pkg::state_e;
  import drum_pkg::ST_IDLE;
  import drum_pkg::ST_PLAY;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SAMPLE_LEN - 1);

  state_e            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        sel_q;
  logic              pend;
  logic [DATA_W-1:0] rom_data;
  logic              trigger, rd_en, at_last;

  assign trigger = ins_signal & slow_clk & play;
  // A trigger in the same cycle as a strobe takes priority, and that strobe's read is dropped.
  assign rd_en   = (state == ST_PLAY) & sample_clk & play & ~trigger;
  assign at_last = (addr == LAST);
  assign busy    = (state == ST_PLAY);

  voice_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
    .clk  (clk),
    .en   (rd_en),
    .addr ({sel_q, addr}),
    .data (rom_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!play)                 state_next = ST_IDLE;
    else if (trigger)          state_next = ST_PLAY;
    else if (rd_en && at_last) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr  <= '0;
      sel_q <= '0;
      pend  <= 1'b0;
      out   <= '0;
    end else begin
      pend <= rd_en;
      if (trigger) begin
        addr  <= '0;
        sel_q <= sel;
      end else if (rd_en && !at_last) begin
        addr <= addr + 1'b1;
      end
      // The last sample can still land just after playback has returned to IDLE.
      // The next idle strobe clears it.
      if (!play)                                out <= '0;
      else if (pend)                            out <= rom_data;
      else if (state == ST_IDLE && sample_clk)  out <= '0;
    end
  end

endmodule

// File: tb/tb_drum_voice.sv
// Directed bench for drum_voice.
// It uses a full-length instance and an 8-sample instance that share one set of inputs.
module tb_drum_voice;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              sample_clk = 1'b0;
  logic              slow_clk = 1'b0;
  logic              play = 1'b0;
  logic              ins_signal = 1'b0;
  logic [1:0]        sel = 2'b00;
  logic signed [7:0] out_a, out_b;
  logic              busy_a, busy_b;
  int                checks = 0;
  int                failures = 0;

  always #10 clk = ~clk;

  drum_voice dut (
    .clk(clk), .reset(reset), .sample_clk(sample_clk), .slow_clk(slow_clk),
    .play(play), .ins_signal(ins_signal), .sel(sel), .out(out_a), .busy(busy_a)
  );

  drum_voice #(.SAMPLE_LEN(8), .ADDR_W(3), .DATA_W(8)) dut8 (
    .clk(clk), .reset(reset), .sample_clk(sample_clk), .slow_clk(slow_clk),
    .play(play), .ins_signal(ins_signal), .sel(sel), .out(out_b), .busy(busy_b)
  );

  // Preloaded contents: each voice is a 0..127 ramp, and the snare (01) ramp starts at 0.
  function automatic logic [7:0] exp_word(input int voice, input int idx);
    return 8'((idx + 32 * (voice ^ 1)) % 128);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe();
    sample_clk = 1'b1;
    tick();
    sample_clk = 1'b0;
  endtask

  task automatic fire(input logic [1:0] s);
    sel = s;
    ins_signal = 1'b1;
    slow_clk = 1'b1;
    tick();
    ins_signal = 1'b0;
    slow_clk = 1'b0;
  endtask

  task automatic do_reset();
    ins_signal = 1'b0;
    slow_clk = 1'b0;
    sample_clk = 1'b0;
    play = 1'b1;
    sel = 2'b00;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    checks++;
    if (out_a !== 8'sd0 || busy_a !== 1'b0 || out_b !== 8'sd0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_state out_a=%0d busy_a=%0b out_b=%0d busy_b=%0b expected 0/0", out_a, busy_a, out_b, busy_b);
    end
    play = 1'b1;
    idle(2);
    reset = 1'b0;
    tick();
    strobe();
    tick();
    strobe();
    tick();
    checks++;
    if (out_a !== 8'sd0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL idle_strobe out=%0d busy=%0b expected 0/0", out_a, busy_a);
    end
  endtask

  task automatic test_playback();
    do_reset();
    fire(2'b01);
    checks++;
    if (busy_a !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_trigger got=%0b expected=1", busy_a);
    end
    for (int k = 0; k < 6; k++) begin
      strobe();
      checks++;
      if (out_a !== ((k == 0) ? 8'd0 : exp_word(1, k - 1))) begin
        failures++;
        $display("FAIL playback_latency k=%0d got=%0d expected=%0d", k, out_a, (k == 0) ? 0 : exp_word(1, k - 1));
      end
      tick();
      checks++;
      if (out_a !== exp_word(1, k) || busy_a !== 1'b1) begin
        failures++;
        $display("FAIL playback_out k=%0d got=%0d busy=%0b expected=%0d busy=1", k, out_a, busy_a, exp_word(1, k));
      end
      idle(1040);
    end
  endtask

  task automatic test_end_of_sample();
    do_reset();
    fire(2'b01);
    for (int k = 0; k < 8; k++) begin
      strobe();
      checks++;
      if (busy_b !== (k < 7)) begin
        failures++;
        $display("FAIL end_busy k=%0d got=%0b expected=%0b", k, busy_b, (k < 7));
      end
      tick();
      checks++;
      if (out_b !== exp_word(1, k)) begin
        failures++;
        $display("FAIL end_out k=%0d got=%0d expected=%0d", k, out_b, exp_word(1, k));
      end
      idle(3);
    end
    strobe();
    checks++;
    if (out_b !== 8'sd0) begin
      failures++;
      $display("FAIL end_ninth_strobe got=%0d expected=0", out_b);
    end
    idle(2);
    strobe();
    tick();
    checks++;
    if (out_b !== 8'sd0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL end_tenth_strobe out=%0d busy=%0b expected 0/0", out_b, busy_b);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    fire(2'b01);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) sel = 2'b10;
      strobe();
      tick();
      checks++;
      if (out_a !== exp_word(1, k)) begin
        failures++;
        $display("FAIL retrig_pre k=%0d got=%0d expected=%0d", k, out_a, exp_word(1, k));
      end
      idle(2);
    end
    fire(2'b11);
    checks++;
    if (busy_a !== 1'b1) begin
      failures++;
      $display("FAIL retrig_busy got=%0b expected=1", busy_a);
    end
    for (int k = 0; k < 2; k++) begin
      strobe();
      tick();
      checks++;
      if (out_a !== exp_word(3, k) || busy_a !== 1'b1) begin
        failures++;
        $display("FAIL retrig_out k=%0d got=%0d busy=%0b expected=%0d busy=1", k, out_a, busy_a, exp_word(3, k));
      end
      idle(2);
    end
  endtask

  task automatic test_coincident();
    do_reset();
    fire(2'b01);
    for (int k = 0; k < 3; k++) begin
      strobe();
      tick();
      idle(2);
    end
    sel = 2'b00;
    ins_signal = 1'b1;
    slow_clk = 1'b1;
    sample_clk = 1'b1;
    tick();
    ins_signal = 1'b0;
    slow_clk = 1'b0;
    sample_clk = 1'b0;
    tick();
    checks++;
    if (out_a !== exp_word(1, 2) || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL coincident_no_read got=%0d busy=%0b expected=%0d busy=1", out_a, busy_a, exp_word(1, 2));
    end
    strobe();
    tick();
    checks++;
    if (out_a !== exp_word(0, 0)) begin
      failures++;
      $display("FAIL coincident_first got=%0d expected=%0d", out_a, exp_word(0, 0));
    end
  endtask

  task automatic test_play_drop();
    do_reset();
    fire(2'b01);
    for (int k = 0; k < 3; k++) begin
      strobe();
      tick();
      idle(2);
    end
    strobe();
    play = 1'b0;
    tick();
    checks++;
    if (out_a !== 8'sd0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL play_drop out=%0d busy=%0b expected 0/0", out_a, busy_a);
    end
    strobe();
    tick();
    play = 1'b1;
    strobe();
    tick();
    strobe();
    tick();
    checks++;
    if (out_a !== 8'sd0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL play_drop_after out=%0d busy=%0b expected 0/0", out_a, busy_a);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fire(2'b01);
    for (int k = 0; k < 3; k++) begin
      strobe();
      tick();
      idle(2);
    end
    strobe();
    #5 reset = 1'b1;
    #1;
    checks++;
    if (out_a !== 8'sd0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_immediate out=%0d busy=%0b expected 0/0", out_a, busy_a);
    end
    #2 reset = 1'b0;
    tick();
    tick();
    checks++;
    if (out_a !== 8'sd0) begin
      failures++;
      $display("FAIL reset_mid_residual got=%0d expected=0", out_a);
    end
    fire(2'b00);
    for (int k = 0; k < 2; k++) begin
      strobe();
      tick();
      checks++;
      if (out_a !== exp_word(0, k)) begin
        failures++;
        $display("FAIL reset_mid_restart k=%0d got=%0d expected=%0d", k, out_a, exp_word(0, k));
      end
      idle(2);
    end
  endtask

  initial begin
    test_reset();
    test_playback();
    test_end_of_sample();
    test_retrigger();
    test_coincident();
    test_play_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drum_voice.md
DRUM_VOICE -- requirements
Module: drum_voice

Interface
REQ-001 Param SAMPLE_LEN, 4096: samples per voice; playback stops after address SAMPLE_LEN-1.
REQ-002 Param ADDR_W, 12: ROM address width, clog2(SAMPLE_LEN).
REQ-003 Param DATA_W, 8: signed sample width.
REQ-004 clk  in  1  50 MHz system clock; sole clock of the block.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 sample_clk  in  1  one-clk-wide 48 kHz advance strobe.
REQ-007 slow_clk  in  1  one-clk-wide step strobe from the bpm block.
REQ-008 play  in  1  sequencer running; low aborts playback.
REQ-009 ins_signal  in  1  step-active flag for this voice from the datapath.
REQ-010 sel  in  2  voice select: 00 kick, 01 snare, 10 hat, 11 clap.
REQ-011 out  out  DATA_W  signed two's-complement sample to the mixer.
REQ-012 busy  out  1  high while state is PLAY.

Function
REQ-013 trigger = ins_signal & slow_clk & play, evaluated each clk edge.
REQ-014 The FSM has two states: IDLE and PLAY.
REQ-015 IDLE->PLAY on trigger: addr<=0, sel_q<=sel, busy high from the next cycle.
REQ-016 sel_q stays fixed for the whole playback; sel changes mid-playback have no effect.
REQ-017 In PLAY, each sample_clk strobe at cycle t issues a synchronous ROM read of {sel_q,addr}.
REQ-018 ROM data is valid at t+1; out is registered at t+1 and visible from t+2 (2-clk latency).
REQ-019 addr increments by 1 at each strobe.
REQ-020 If the strobe at t reads addr==SAMPLE_LEN-1: state->IDLE at t+1, final sample still reaches out at t+2, out<=0 at the next strobe.
REQ-021 Retrigger in PLAY: addr<=0, sel_q<=sel, state stays PLAY, no IDLE cycle.
REQ-022 Trigger coincident with a strobe: trigger wins, that strobe is ignored, no read issued.
REQ-023 play low in PLAY: state->IDLE and out<=0 on the next edge; in-flight ROM data is discarded.
REQ-024 In IDLE, out holds 0 and sample_clk strobes have no effect.
REQ-025 addr never exceeds SAMPLE_LEN-1 and never wraps to 0 except by trigger.

Reset
REQ-026 reset asserted: state=IDLE, addr=0, sel_q=0, out=0, busy=0, pending-read flag=0, all immediately and independent of clk.
REQ-027 Reset mid-playback aborts with no residual output; the first trigger after release starts from addr 0.

Structure
REQ-028 A shared drum_pkg holds the voice-select encodings, SAMPLE_LEN, ADDR_W, DATA_W and the state encoding.
REQ-029 Sub-module voice_rom: 4*SAMPLE_LEN x DATA_W synchronous-read ROM, one registered read port, initialised from per-voice memory files.
REQ-030 drum_voice contains the FSM, address counter, pending-read flag and output register only.

Verification
REQ-031 ROM preloaded with sample[i]=i mod 128. Trigger with sel=01, strobes every 1042 clk -> out=0,1,2,... each appearing 2 clk after its strobe; busy=1.
REQ-032 SAMPLE_LEN=8, trigger, 10 strobes -> out 0..7; busy falls 1 clk after the 8th strobe; out=0 at the 9th strobe; 10th strobe has no effect.
REQ-033 Retrigger after 5 samples with sel changed to 11 -> next output is voice-11 addr 0; busy never drops.
REQ-034 Trigger and strobe in the same cycle -> no read that cycle; first output comes from the following strobe, addr 0.
REQ-035 play dropped after 3 samples -> out=0 next edge, busy=0, no further outputs despite strobes.
REQ-036 reset pulsed mid-playback between clk edges -> out=0 and busy=0 immediately; next trigger plays from addr 0.
